modport_regs: RTL and testbench



---
 rtl/modport_regs.sv | 176 +++++++++++++++++
 tb/tb_modport_regs.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/modport_regs.sv
// Register-bus slave around a DEPTH-entry word FIFO with control, status,
// threshold, scratch and ID registers; one registered completion per request.
module modport_regs #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_STATUS  = 3'd1;
  localparam logic [2:0] A_TXDATA  = 3'd2;
  localparam logic [2:0] A_RXDATA  = 3'd3;
  localparam logic [2:0] A_COUNT   = 3'd4;
  localparam logic [2:0] A_THRESH  = 3'd5;
  localparam logic [2:0] A_SCRATCH = 3'd6;
  localparam logic [2:0] A_ID      = 3'd7;

  localparam logic [DATA_W-1:0] ID_VALUE = DATA_W'(32'hF1F0_0001);

  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              en_q, en_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [CNT_W-1:0]  thresh_q, thresh_d;
  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic [CNT_W-1:0]  wptr_q, wptr_d;
  logic [CNT_W-1:0]  rptr_q, rptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              push_en;
  logic              accept;
  logic              wr_acc;
  logic              rd_acc;
  logic              bad_acc;
  logic              hit;
  logic [2:0]        idx;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              afull;
  logic              unused_bits;

  assign unused_bits = ^addr[1:0];

  assign hit   = (addr[ADDR_W-1:5] == '0);
  assign idx   = addr[4:2];
  assign count = wptr_q - rptr_q;
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign afull = (count >= thresh_q);

  // Request lines are ignored while ready is high, so each request fires once.
  assign accept  = (wen | ren) & ~ready_q;
  assign wr_acc  = accept & wen & ~ren;
  assign rd_acc  = accept & ren & ~wen;
  assign bad_acc = accept & wen & ren;

  always_comb begin
    ready_d   = accept;
    rdata_d   = rdata_q;
    en_d      = en_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    thresh_d  = thresh_q;
    scratch_d = scratch_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    push_en   = 1'b0;

    if (wr_acc && hit) begin
      case (idx)
        A_CTRL: begin
          en_d = wdata[0];
          if (wdata[1]) begin
            wptr_d = '0;
            rptr_d = '0;
          end
        end
        A_STATUS: begin
          ovf_d = ovf_q & ~wdata[2];
          udf_d = udf_q & ~wdata[3];
        end
        A_TXDATA: begin
          if (en_q) begin
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              push_en = 1'b1;
              wptr_d  = wptr_q + 1'b1;
            end
          end
        end
        A_THRESH:  thresh_d  = wdata[CNT_W-1:0];
        A_SCRATCH: scratch_d = wdata;
        default: ;
      endcase
    end

    if (bad_acc) begin
      rdata_d = '0;
    end

    if (rd_acc) begin
      rdata_d = '0;
      if (hit) begin
        case (idx)
          A_CTRL:    rdata_d = DATA_W'(en_q);
          A_STATUS:  rdata_d = DATA_W'({afull, udf_q, ovf_q, full, empty});
          A_RXDATA: begin
            if (en_q) begin
              if (empty) begin
                udf_d = 1'b1;
              end else begin
                rdata_d = mem_q[rptr_q[PTR_W-1:0]];
                rptr_d  = rptr_q + 1'b1;
              end
            end
          end
          A_COUNT:   rdata_d = DATA_W'(count);
          A_THRESH:  rdata_d = DATA_W'(thresh_q);
          A_SCRATCH: rdata_d = scratch_q;
          A_ID:      rdata_d = ID_VALUE;
          default:   rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      en_q      <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      thresh_q  <= CNT_W'(DEPTH - 1);
      scratch_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      en_q      <= en_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      thresh_q  <= thresh_d;
      scratch_q <= scratch_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  // Storage has no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_en && !rst) begin
      mem_q[wptr_q[PTR_W-1:0]] <= wdata;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_modport_regs.sv
// Directed self-checking bench for modport_regs: register map, FIFO
// ordering, sticky flags, flush, enable, held/illegal requests and reset.
module tb_modport_regs;

  localparam logic [7:0] A_CTRL    = 8'h00;
  localparam logic [7:0] A_STATUS  = 8'h04;
  localparam logic [7:0] A_TXDATA  = 8'h08;
  localparam logic [7:0] A_RXDATA  = 8'h0C;
  localparam logic [7:0] A_COUNT   = 8'h10;
  localparam logic [7:0] A_THRESH  = 8'h14;
  localparam logic [7:0] A_SCRATCH = 8'h18;
  localparam logic [7:0] A_ID      = 8'h1C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] rdata;
  logic        ready;

  int errors = 0;
  int checks = 0;

  modport_regs #(.ADDR_W(8), .DATA_W(32), .DEPTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wdata (wdata),
    .wen   (wen),
    .ren   (ren),
    .rdata (rdata),
    .ready (ready)
  );

  always #5 clk = ~clk;

  // Drive one request and hold it until ready is seen; optionally keep it
  // asserted through the following (ignored) edge.
  task automatic xfer(input logic [7:0] a, input logic [31:0] d, input logic w,
                      input logic r, input bit hold_extra, output logic [31:0] q);
    int n;
    @(negedge clk);
    addr = a; wdata = d; wen = w; ren = r;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready && n < 20);
    if (!ready) begin
      checks++; errors++;
      $display("FAIL timeout addr=%h: no ready after %0d cycles", a, n);
    end
    q = rdata;
    if (hold_extra) begin
      @(posedge clk); #1;
    end
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] q;
    xfer(a, d, 1'b1, 1'b0, 1'b0, q);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] q);
    xfer(a, 32'h0, 1'b0, 1'b1, 1'b0, q);
  endtask

  task automatic test_reset();
    logic [31:0] q;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    @(negedge clk); rst = 1'b0;
    rd(A_STATUS, q);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL reset_status got=%h exp=1", q); end
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_pulse_width got=%b exp=0", ready); end
    rd(A_CTRL, q);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL reset_ctrl got=%h exp=1", q); end
    rd(A_THRESH, q);
    checks++; if (q !== 32'hF) begin errors++; $display("FAIL reset_thresh got=%h exp=f", q); end
    rd(A_ID, q);
    checks++; if (q !== 32'hF1F0_0001) begin errors++; $display("FAIL id got=%h exp=f1f00001", q); end
    rd(A_SCRATCH, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_scratch got=%h exp=0", q); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] q;
    for (int i = 0; i < 16; i++) wr(A_TXDATA, 32'hA0 + i);
    rd(A_COUNT, q);
    checks++; if (q !== 32'd16) begin errors++; $display("FAIL full_count got=%0d exp=16", q); end
    rd(A_STATUS, q);
    checks++; if (q !== 32'h12) begin errors++; $display("FAIL full_status got=%h exp=12", q); end
    wr(A_TXDATA, 32'hBB);
    rd(A_STATUS, q);
    checks++; if (q !== 32'h16) begin errors++; $display("FAIL ovf_status got=%h exp=16", q); end
    rd(A_COUNT, q);
    checks++; if (q !== 32'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", q); end
    for (int i = 0; i < 16; i++) begin
      rd(A_RXDATA, q);
      checks++;
      if (q !== 32'hA0 + i) begin errors++; $display("FAIL pop_%0d got=%h exp=%h", i, q, 32'hA0 + i); end
    end
    rd(A_STATUS, q);
    checks++; if (q !== 32'h5) begin errors++; $display("FAIL drained_status got=%h exp=5", q); end
  endtask

  task automatic test_underflow();
    logic [31:0] q;
    wr(A_STATUS, 32'h4);
    rd(A_STATUS, q);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL ovf_w1c got=%h exp=1", q); end
    rd(A_RXDATA, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL udf_rdata got=%h exp=0", q); end
    rd(A_STATUS, q);
    checks++; if (q !== 32'h9) begin errors++; $display("FAIL udf_status got=%h exp=9", q); end
    wr(A_STATUS, 32'h8);
    rd(A_STATUS, q);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL udf_w1c got=%h exp=1", q); end
  endtask

  task automatic test_thresh_flush();
    logic [31:0] q;
    for (int i = 0; i < 5; i++) wr(A_TXDATA, 32'hC0 + i);
    rd(A_STATUS, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL five_status got=%h exp=0", q); end
    wr(A_THRESH, 32'h4);
    rd(A_STATUS, q);
    checks++; if (q !== 32'h10) begin errors++; $display("FAIL afull_status got=%h exp=10", q); end
    wr(A_CTRL, 32'h3);
    rd(A_COUNT, q);
    checks++; if (q !== 32'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", q); end
    rd(A_STATUS, q);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL flush_status got=%h exp=1", q); end
    rd(A_CTRL, q);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL flush_ctrl got=%h exp=1", q); end
    rd(A_THRESH, q);
    checks++; if (q !== 32'h4) begin errors++; $display("FAIL flush_thresh got=%h exp=4", q); end
  endtask

  task automatic test_disable_regs();
    logic [31:0] q;
    wr(A_CTRL, 32'h0);
    wr(A_TXDATA, 32'h55);
    rd(A_COUNT, q);
    checks++; if (q !== 32'd0) begin errors++; $display("FAIL dis_push_count got=%0d exp=0", q); end
    rd(A_RXDATA, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL dis_pop_rdata got=%h exp=0", q); end
    rd(A_STATUS, q);
    checks++; if (q !== 32'h1) begin errors++; $display("FAIL dis_status got=%h exp=1", q); end
    rd(A_CTRL, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL dis_ctrl got=%h exp=0", q); end
    wr(A_CTRL, 32'h1);
    wr(A_SCRATCH, 32'hDEADBEEF);
    wr(8'h40, 32'h1234_5678);
    wr(A_ID, 32'h0);
    rd(A_SCRATCH, q);
    checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL scratch got=%h exp=deadbeef", q); end
    rd(8'h40, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL unmapped got=%h exp=0", q); end
    rd(A_TXDATA, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL txdata_read got=%h exp=0", q); end
    rd(A_ID, q);
    checks++; if (q !== 32'hF1F0_0001) begin errors++; $display("FAIL id_ro got=%h exp=f1f00001", q); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q;
    xfer(A_TXDATA, 32'h11, 1'b1, 1'b0, 1'b1, q);
    rd(A_COUNT, q);
    checks++; if (q !== 32'd1) begin errors++; $display("FAIL held_wen_count got=%0d exp=1", q); end
    rd(A_SCRATCH, q);
    xfer(A_RXDATA, 32'h99, 1'b1, 1'b1, 1'b0, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL illegal_rdata got=%h exp=0", q); end
    rd(A_COUNT, q);
    checks++; if (q !== 32'd1) begin errors++; $display("FAIL illegal_count got=%0d exp=1", q); end
    rd(A_RXDATA, q);
    checks++; if (q !== 32'h11) begin errors++; $display("FAIL illegal_pop got=%h exp=11", q); end
    wr(A_SCRATCH, 32'h0000_00AA);
    wr(A_CTRL, 32'h1);
    rd(A_SCRATCH, q);
    checks++; if (q !== 32'hAA) begin errors++; $display("FAIL b2b_scratch got=%h exp=aa", q); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q;
    @(negedge clk);
    addr = A_SCRATCH; ren = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got=%b exp=0", ready); end
    @(negedge clk); ren = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_reset_discard got=%b exp=0", ready); end
    rd(A_SCRATCH, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL mid_reset_scratch got=%h exp=0", q); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_underflow();
    test_thresh_flush();
    test_disable_regs();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
